// File: rtl/calculator_pkg.sv
// Shared calculator types: SRAM geometry, arbiter owner encoding and read-return tags.
// Types and constants only; no logic.
package calculator_pkg;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 64;
  localparam int ARB_CNT_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CTRL = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_CTRL) ? OWN_HOST : OWN_CTRL;
  endfunction

endpackage

// File: rtl/calc_rd_tag_pipe.sv
// Delays read-return tags by exactly RD_LAT cycles to line up with SRAM read data.
// No backpressure: one tag enters and one leaves every cycle; async clear drops tags in flight.
module calc_rd_tag_pipe
  import calculator_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe [RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[RD_LAT-1];

endmodule

// File: rtl/calc_sram_arbiter.sv
// Arbitrates CTRL and HOST onto the split SRAM pair; grant is combinational, reads return RD_LAT cycles later.
// Ungranted requesters hold their command until granted; locked bursts yield after MAX_HOLD grants under contention.
module calc_sram_arbiter #(
  parameter int ADDR_W   = calculator_pkg::ADDR_W,
  parameter int DATA_W   = calculator_pkg::DATA_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 c_req,
  input  logic                                 c_lock,
  input  logic                                 c_we,
  input  logic [ADDR_W-1:0]                    c_addr,
  input  logic [DATA_W-1:0]                    c_wdata,
  output logic                                 c_gnt,
  output logic                                 c_rvalid,
  input  logic                                 h_req,
  input  logic                                 h_lock,
  input  logic                                 h_we,
  input  logic [ADDR_W-1:0]                    h_addr,
  input  logic [DATA_W-1:0]                    h_wdata,
  output logic                                 h_gnt,
  output logic                                 h_rvalid,
  output logic [DATA_W-1:0]                    rdata,
  output logic                                 sram_cs,
  output logic                                 sram_we,
  output logic [ADDR_W-1:0]                    sram_addr,
  output logic [31:0]                          sram_wdata_lo,
  output logic [31:0]                          sram_wdata_hi,
  input  logic [31:0]                          sram_rdata_lo,
  input  logic [31:0]                          sram_rdata_hi,
  output logic [calculator_pkg::ARB_CNT_W-1:0] conflict_cnt
);

  import calculator_pkg::*;

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  owner_e              owner;
  owner_e              last_gnt;
  owner_e              gnt_own;
  logic                locked;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                own_req;
  logic                oth_req;
  logic                sel_we;
  logic                sel_lock;
  logic [DATA_W-1:0]   sel_wdata;
  rd_tag_t             tag_in;
  rd_tag_t             tag_out;

  always_comb begin
    own_req = 1'b0;
    oth_req = 1'b0;
    if (owner == OWN_CTRL) begin
      own_req = c_req;
      oth_req = h_req;
    end else if (owner == OWN_HOST) begin
      own_req = h_req;
      oth_req = c_req;
    end

    // Reset gates the grant so every output reads 0 while rst is low.
    gnt_own = OWN_NONE;
    if (!rst)
      gnt_own = OWN_NONE;
    else if (locked && own_req && !(oth_req && hold_cnt == HOLD_MAX))
      gnt_own = owner;
    else if (c_req && !h_req)
      gnt_own = OWN_CTRL;
    else if (h_req && !c_req)
      gnt_own = OWN_HOST;
    else if (c_req && h_req)
      gnt_own = other_owner(last_gnt);
  end

  assign c_gnt   = (gnt_own == OWN_CTRL);
  assign h_gnt   = (gnt_own == OWN_HOST);
  assign sram_cs = c_gnt | h_gnt;

  always_comb begin
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_wdata = '0;
    sram_addr = '0;
    if (c_gnt) begin
      sel_we    = c_we;
      sel_lock  = c_lock;
      sel_wdata = c_wdata;
      sram_addr = c_addr;
    end else if (h_gnt) begin
      sel_we    = h_we;
      sel_lock  = h_lock;
      sel_wdata = h_wdata;
      sram_addr = h_addr;
    end
  end

  assign sram_we       = sel_we;
  assign sram_wdata_lo = sel_wdata[31:0];
  assign sram_wdata_hi = sel_wdata[63:32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner        <= OWN_NONE;
      last_gnt     <= OWN_HOST;
      locked       <= 1'b0;
      hold_cnt     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (c_req && h_req && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + 1'b1;

      if (gnt_own != OWN_NONE) begin
        last_gnt <= gnt_own;
        owner    <= gnt_own;
        locked   <= sel_lock;
        if (gnt_own != owner)
          hold_cnt <= HOLD_W'(1);
        else if (hold_cnt != HOLD_MAX)
          hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
        owner    <= OWN_NONE;
        locked   <= 1'b0;
        hold_cnt <= '0;
      end
    end
  end

  assign tag_in.valid = sram_cs & ~sel_we;
  assign tag_in.owner = tag_in.valid ? gnt_own : OWN_NONE;

  calc_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign c_rvalid = tag_out.valid && (tag_out.owner == OWN_CTRL);
  assign h_rvalid = tag_out.valid && (tag_out.owner == OWN_HOST);
  assign rdata    = (c_rvalid || h_rvalid) ? {sram_rdata_hi, sram_rdata_lo} : '0;

endmodule
